seq_gen_serial_moore: RTL and testbench
=======================================

# seq_gen_serial_moore

Serial pattern generator, the transmit-side counterpart of the serial sequence detectors. It latches a parallel bit pattern and bit length on a start request and shifts the pattern out MSB-first, one bit per clock, on a Moore-registered serial output with a valid qualifier. It produces stimulus and framing for detector blocks such as the 111 detector, and serves as a general serial bit source in the design.

## Interface
- `WIDTH`, 8: maximum pattern length in bits; must be ≥ 2.
- `CNT_W`, $clog2(WIDTH)+1: bit-counter width. Fixed by `WIDTH`; do not override.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send, MSB first; sampled with `start`.
- `len`  in  CNT_W  number of bits to send, sampled with `start`.
- `repeat`  in  1  continuous-mode request; present only with `SEQ_GEN_REPEAT_EN`.
- `d_out`  out  1  serial data bit.
- `d_valid`  out  1  `d_out` is a live pattern bit this cycle.
- `busy`  out  1  transmission in progress (SHIFT or DONE).
- `done`  out  1  single-cycle end-of-transmission pulse.

## Operation
- Moore FSM with 3 states: IDLE, SHIFT, DONE. All outputs are decoded from registered state only.
- **IDLE**
  - Outputs: `d_out`=0, `d_valid`=0, `busy`=0, `done`=0.
  - If `start`=1, latch `pattern` into the shift register and into the reload copy, load the counter with L-1, and go to SHIFT.
- **SHIFT**
  - Outputs: `d_out`=`shreg[WIDTH-1]`, `d_valid`=1, `busy`=1.
  - Each edge: shift `shreg` left by 1 (zero fill) and decrement the counter.
  - When the counter equals 0 at an edge, go to DONE.
- **DONE**
  - Outputs: `done`=1, `busy`=1, `d_valid`=0, `d_out`=0.
  - Unconditionally go to IDLE.
- **Effective length L**
  - `len`=0 or `len`>`WIDTH` gives L=`WIDTH`.
  - Otherwise L=`len`.
  - Only the top L bits of `pattern` are sent.
- **Start handling**
  - `start` is ignored in SHIFT and DONE; it is not queued.
  - `pattern` and `len` changes after the start cycle have no effect on the current transmission.
- **Reset**
  - `rst_n` low forces IDLE, clears the shift register, counter, and reload copy, and drives all outputs to 0 immediately (asynchronous).
  - Reset mid-transmission aborts the transmission; no `done` pulse is produced.
  - Release is synchronous-safe: the first active edge after deassertion evaluates IDLE.
- `d_out` is 0 whenever `d_valid`=0. There are no X or stale bits.

## Timing
- `start`=1 sampled at edge N gives the first bit in cycle N+1.
- Bits occupy cycles N+1 … N+L with no gaps.
- `done`=1 in cycle N+L+1.
- IDLE in cycle N+L+2. This is the earliest edge at which a new `start` is accepted.
- Minimum start-to-start period is L+2 cycles.
- `busy` rises at N+1 and falls at N+L+2.

## Configuration
- **`SEQ_GEN_REPEAT_EN` defined**
  - The `repeat` port exists.
  - In SHIFT, at the edge where the counter is 0: if `repeat`=1, reload `shreg` from the latched reload copy, reload the counter with L-1, and stay in SHIFT.
  - On repeat, `done` is not pulsed and there is no gap cycle; the first bit of the next copy follows the last bit immediately.
  - `repeat`=0 at that edge ends the transmission normally through DONE.
- **`SEQ_GEN_REPEAT_EN` undefined**
  - The `repeat` port is absent.
  - Behaviour is identical to `repeat`=0.

## Test plan
- Reset: `rst_n`=0 with random inputs → all outputs 0 and state IDLE, checked asynchronously before any clock edge.
- Basic 111 frame: `WIDTH`=8, `pattern`=8'b1110_0000, `len`=3, `start` pulsed at N → `d_out`=1,1,1 with `d_valid`=1 in N+1..N+3; `done`=1 in N+4; `busy` low from N+5.
- Full and clamped length: `pattern`=8'hA5, `len`=0, then repeat with `len`=12 → both give 1,0,1,0,0,1,0,1 over 8 cycles, then `done`.
- Busy ignore: `start` held high throughout with `pattern` changed mid-frame → the original frame is unaltered; the next frame starts exactly at N+L+2 with the new pattern.
- Abort: `rst_n` pulsed low during the 2nd bit of a 5-bit frame → outputs 0 immediately, no `done`; after release a fresh `start` sends a complete frame.
- `SEQ_GEN_REPEAT_EN`: `pattern`=8'b1100_0000, `len`=2, `repeat`=1 for 3 frames, then 0 → `d_out`=1,1,1,1,1,1 with `d_valid` continuous for 6 cycles; a single `done` pulse after the 6th bit.

Source files
------------

// File: rtl/seq_gen_serial_moore.sv
// Serial pattern generator: latches a pattern/length on start and shifts it out MSB-first.
// Optional SEQ_GEN_REPEAT_EN adds continuous mode via repeat_mode (repeat is a reserved word).
module seq_gen_serial_moore #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_mode,
`endif
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] load_cnt_c;
  logic             d_out_nxt, d_valid_nxt, busy_nxt, done_nxt;

`ifdef SEQ_GEN_REPEAT_EN
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [CNT_W-1:0] len_m1, len_m1_nxt;
`endif

  // Effective length minus one: zero or oversize lengths send the full pattern
  always_comb begin
    load_cnt_c = len - CNT_W'(1);
    if ((len == '0) || (len > CNT_W'(WIDTH))) begin
      load_cnt_c = CNT_W'(WIDTH - 1);
    end
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef SEQ_GEN_REPEAT_EN
    reload_nxt = reload;
    len_m1_nxt = len_m1;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt = pattern;
          cnt_nxt   = load_cnt_c;
          state_nxt = SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
          reload_nxt = pattern;
          len_m1_nxt = load_cnt_c;
`endif
        end
      end
      SHIFT: begin
        shreg_nxt = shreg << 1;
        if (cnt == '0) begin
          state_nxt = DONE;
`ifdef SEQ_GEN_REPEAT_EN
          if (repeat_mode) begin
            shreg_nxt = reload;
            cnt_nxt   = len_m1;
            state_nxt = SHIFT;
          end
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are a pure function of the state being entered, then registered
    d_valid_nxt = (state_nxt == SHIFT);
    d_out_nxt   = (state_nxt == SHIFT) ? shreg_nxt[WIDTH-1] : 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      d_out   <= 1'b0;
      d_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      reload  <= '0;
      len_m1  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      d_out   <= d_out_nxt;
      d_valid <= d_valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef SEQ_GEN_REPEAT_EN
      reload  <= reload_nxt;
      len_m1  <= len_m1_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seq_gen_serial_moore.sv
// Self-checking bench for seq_gen_serial_moore: per-cycle vector table with an expected-output queue.
module tb_seq_gen_serial_moore;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] len;
  logic             d_out, d_valid, busy, done;
`ifdef SEQ_GEN_REPEAT_EN
  logic             repeat_mode;
`endif

  seq_gen_serial_moore #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .len     (len),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_mode (repeat_mode),
`endif
    .d_out   (d_out),
    .d_valid (d_valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {d_out, d_valid, busy, done} after the edge that samples the inputs
  typedef struct packed {
    logic             start;
    logic [WIDTH-1:0] pat;
    logic [CNT_W-1:0] len;
    logic             rpt;
    logic [3:0]       exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_q[$];
  int         errors;
  int         checks;

  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_B1   = 4'b1110;
  localparam logic [3:0] O_B0   = 4'b0110;
  localparam logic [3:0] O_DONE = 4'b0011;

  function automatic void add(input logic s, input logic [WIDTH-1:0] p,
                              input logic [CNT_W-1:0] l, input logic r,
                              input logic [3:0] e);
    vec_t v;
    v.start = s; v.pat = p; v.len = l; v.rpt = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {d_out, d_valid, busy, done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: d_out/d_valid/busy/done got=%b required=%b", name, got, exp);
    end
  endtask

  // Drive each vector on the falling edge, push its expectation, pop and compare after the rising edge
  task automatic run_vecs(input string tag);
    logic [3:0] e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start   = vecs[i].start;
      pattern = vecs[i].pat;
      len     = vecs[i].len;
`ifdef SEQ_GEN_REPEAT_EN
      repeat_mode = vecs[i].rpt;
`endif
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL %s[%0d]: scoreboard empty", tag, i);
      end else begin
        e = sb_q.pop_front();
        check_outs($sformatf("%s[%0d]", tag, i), e);
      end
    end
    vecs.delete();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
`ifdef SEQ_GEN_REPEAT_EN
    repeat_mode = 1'b0;
`endif

    // Asynchronous reset with random inputs, before any clock edge
    #1;
    rst_n   = 1'b0;
    start   = 1'b1;
    pattern = WIDTH'($urandom);
    len     = CNT_W'($urandom);
    #1;
    check_outs("reset_async", O_IDLE);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_held", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_outs("reset_release_idle", O_IDLE);

    // 111 frame, len=3
    add(1, 8'hE0, 3, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_DONE);
    add(0, 8'h00, 0, 0, O_IDLE);
    // A5 with len=0 (full width), then len=12 (clamped)
    for (int k = 0; k < 2; k++) begin
      add(1, 8'hA5, (k == 0) ? 4'd0 : 4'd12, 0, O_B1);
      add(0, 8'h00, 0, 0, O_B0);
      add(0, 8'h00, 0, 0, O_B1);
      add(0, 8'h00, 0, 0, O_B0);
      add(0, 8'h00, 0, 0, O_B0);
      add(0, 8'h00, 0, 0, O_B1);
      add(0, 8'h00, 0, 0, O_B0);
      add(0, 8'h00, 0, 0, O_B1);
      add(0, 8'h00, 0, 0, O_DONE);
      add(0, 8'h00, 0, 0, O_IDLE);
    end
    // Single-bit frames: a 1 and a valid 0
    add(1, 8'h80, 1, 0, O_B1);
    add(0, 8'h00, 0, 0, O_DONE);
    add(0, 8'h00, 0, 0, O_IDLE);
    add(1, 8'h7F, 1, 0, O_B0);
    add(0, 8'hFF, 0, 0, O_DONE);
    add(0, 8'hFF, 0, 0, O_IDLE);
    // Explicit len=8
    add(1, 8'h3C, 8, 0, O_B0);
    add(0, 8'h00, 0, 0, O_B0);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B0);
    add(0, 8'h00, 0, 0, O_B0);
    add(0, 8'h00, 0, 0, O_DONE);
    add(0, 8'h00, 0, 0, O_IDLE);
    // start held high, pattern/len changing mid-frame; next frame at N+L+2
    add(1, 8'hB0, 4, 0, O_B1);
    add(1, 8'hFF, 4, 0, O_B0);
    add(1, 8'h00, 4, 0, O_B1);
    add(1, 8'hFF, 2, 0, O_B1);
    add(1, 8'hFF, 2, 0, O_DONE);
    add(1, 8'hFF, 2, 0, O_IDLE);
    add(1, 8'h40, 2, 0, O_B0);
    add(0, 8'hFF, 2, 0, O_B1);
    add(0, 8'hFF, 2, 0, O_DONE);
    add(0, 8'hFF, 2, 0, O_IDLE);
    run_vecs("frames");

    // Abort: reset during the 2nd bit of a 5-bit frame (1,0,1,0,1)
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'hA8;
    len     = 4'd5;
    @(posedge clk);
    #1;
    check_outs("abort_bit1", O_B1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_outs("abort_bit2", O_B0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("abort_async", O_IDLE);
    @(posedge clk);
    #1;
    check_outs("abort_held", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("abort_no_done[%0d]", k), O_IDLE);
    end

    // Fresh complete frame after abort
    add(1, 8'hA8, 5, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B0);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_B0);
    add(0, 8'h00, 0, 0, O_B1);
    add(0, 8'h00, 0, 0, O_DONE);
    add(0, 8'h00, 0, 0, O_IDLE);
    run_vecs("after_abort");

`ifdef SEQ_GEN_REPEAT_EN
    // Three back-to-back 2-bit copies, then a single done
    add(1, 8'hC0, 2, 1, O_B1);
    add(0, 8'h00, 0, 1, O_B1);
    add(0, 8'h00, 0, 1, O_B1);
    add(0, 8'h00, 0, 1, O_B1);
    add(0, 8'h00, 0, 1, O_B1);
    add(0, 8'h00, 0, 1, O_B1);
    add(0, 8'h00, 0, 0, O_DONE);
    add(0, 8'h00, 0, 0, O_IDLE);
    run_vecs("repeat");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
